// File: rtl/lamp_pkg.sv
// Shared mode encodings, key indices and request priority for the lamp mode
// scheduler and the tail-lamp block.
package lamp_pkg;

  localparam int unsigned NUM_KEYS = 5;
  localparam int unsigned KEY_W    = 3;
  localparam int unsigned MODE_W   = 4;

  localparam logic [KEY_W-1:0] K_GO    = 3'd0;
  localparam logic [KEY_W-1:0] K_LEFT  = 3'd1;
  localparam logic [KEY_W-1:0] K_RIGHT = 3'd2;
  localparam logic [KEY_W-1:0] K_BACK  = 3'd3;
  localparam logic [KEY_W-1:0] K_STOP  = 3'd4;

  localparam logic [MODE_W-1:0] MODE_STOP  = 4'b0000;
  localparam logic [MODE_W-1:0] MODE_GO    = 4'b0001;
  localparam logic [MODE_W-1:0] MODE_LEFT  = 4'b0010;
  localparam logic [MODE_W-1:0] MODE_RIGHT = 4'b0100;
  localparam logic [MODE_W-1:0] MODE_BACK  = 4'b1000;

  typedef enum logic [MODE_W-1:0] {
    S_STOP  = MODE_STOP,
    S_GO    = MODE_GO,
    S_LEFT  = MODE_LEFT,
    S_RIGHT = MODE_RIGHT,
    S_BACK  = MODE_BACK
  } mode_e;

  // Index 0 is the highest priority.
  localparam logic [KEY_W-1:0] PRIO [NUM_KEYS] = '{K_STOP, K_BACK, K_LEFT, K_RIGHT, K_GO};

  function automatic mode_e key_mode(input logic [KEY_W-1:0] k);
    mode_e m;
    case (k)
      K_GO:    m = S_GO;
      K_LEFT:  m = S_LEFT;
      K_RIGHT: m = S_RIGHT;
      K_BACK:  m = S_BACK;
      default: m = S_STOP;
    endcase
    return m;
  endfunction

  function automatic logic is_legal(input mode_e cur, input mode_e nxt);
    logic ok;
    ok = 1'b0;
    if (nxt == S_STOP) begin
      ok = 1'b1;
    end else begin
      case (cur)
        S_STOP:  ok = (nxt == S_GO)   || (nxt == S_BACK);
        S_GO:    ok = (nxt == S_LEFT) || (nxt == S_RIGHT);
        S_LEFT:  ok = (nxt == S_GO)   || (nxt == S_RIGHT);
        S_RIGHT: ok = (nxt == S_GO)   || (nxt == S_LEFT);
        default: ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button: 2-flop synchroniser, run-length debouncer and a one-cycle
// press pulse. A key held through reset must be seen released before it arms.
module key_debounce #(
  parameter int unsigned DEB_CYCLES = 240_000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_n,
  output logic press
);

  localparam int unsigned RUN_W = $clog2(DEB_CYCLES + 1);

  logic             sync1_q, sync2_q;
  logic             last_q;
  logic [RUN_W-1:0] run_q, run_d;
  logic             deb_q, deb_d;
  logic             armed_q, armed_d;
  logic             press_q, press_d;
  logic             sample;
  logic             accept;

  // run_d counts consecutive equal samples; the level is accepted at DEB_CYCLES.
  always_comb begin
    sample = ~sync2_q;
    run_d  = run_q;
    if (sample != last_q) begin
      run_d = RUN_W'(1);
    end else if (run_q < RUN_W'(DEB_CYCLES)) begin
      run_d = run_q + RUN_W'(1);
    end
    accept  = (run_d == RUN_W'(DEB_CYCLES));
    deb_d   = accept ? sample : deb_q;
    armed_d = armed_q | (accept & ~sample);
    press_d = deb_d & ~deb_q & armed_q;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      last_q  <= 1'b0;
      run_q   <= '0;
      deb_q   <= 1'b0;
      armed_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      last_q  <= sample;
      run_q   <= run_d;
      deb_q   <= deb_d;
      armed_q <= armed_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/lamp_mode_sched.sv
// Driving-mode scheduler: debounced key requests are latched, arbitrated by
// fixed priority, legality-checked and gated by a minimum dwell time.
module lamp_mode_sched
  import lamp_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = 240_000,
  parameter int unsigned HOLD_CYCLES = 6_000_000,
  parameter int unsigned TURN_CYCLES = 60_000_000
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [MODE_W-1:0]   state_out,
  output logic                mode_chg,
  output logic                busy,
  output logic                req_err
);

  localparam int unsigned DWELL_W = $clog2(TURN_CYCLES + 1);

  logic [NUM_KEYS-1:0] press_vec;
  mode_e               state_q, state_d;
  logic [NUM_KEYS-1:0] pend_q, pend_d, clr;
  logic [DWELL_W-1:0]  dwell_q, dwell_d;
  logic                mode_chg_q, req_err_q, busy_q, busy_d;
  logic                chg, err;
  logic                sel_valid;
  logic [KEY_W-1:0]    sel_key;
  mode_e               sel_mode;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
    ) u_deb (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .key_n     (key_n[i]),
      .press     (press_vec[i])
    );
  end

  // Arbitration, legality check and dwell/auto-cancel handling.
  always_comb begin
    state_d   = state_q;
    clr       = '0;
    chg       = 1'b0;
    err       = 1'b0;
    sel_valid = 1'b0;
    sel_key   = K_GO;
    for (int i = int'(NUM_KEYS) - 1; i >= 0; i--) begin
      if (pend_q[PRIO[KEY_W'(i)]]) begin
        sel_valid = 1'b1;
        sel_key   = PRIO[KEY_W'(i)];
      end
    end
    sel_mode = key_mode(sel_key);

    if (sel_valid && ((sel_key == K_STOP) || !busy_q)) begin
      if (sel_mode == state_q) begin
        clr[sel_key] = 1'b1;
      end else if (is_legal(state_q, sel_mode)) begin
        state_d = sel_mode;
        chg     = 1'b1;
        clr     = '1;
      end else begin
        clr[sel_key] = 1'b1;
        err          = 1'b1;
      end
    end else if (!sel_valid && ((state_q == S_LEFT) || (state_q == S_RIGHT)) &&
                 (dwell_q == DWELL_W'(TURN_CYCLES))) begin
      state_d = S_GO;
      chg     = 1'b1;
    end

    // A press landing on a clear survives.
    pend_d = (pend_q & ~clr) | press_vec;

    if (chg) begin
      dwell_d = '0;
    end else if (dwell_q < DWELL_W'(TURN_CYCLES)) begin
      dwell_d = dwell_q + DWELL_W'(1);
    end else begin
      dwell_d = dwell_q;
    end
    busy_d = (dwell_d < DWELL_W'(HOLD_CYCLES));
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= S_STOP;
      pend_q     <= '0;
      dwell_q    <= DWELL_W'(HOLD_CYCLES);
      mode_chg_q <= 1'b0;
      req_err_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      dwell_q    <= dwell_d;
      mode_chg_q <= chg;
      req_err_q  <= err;
      busy_q     <= busy_d;
    end
  end

  assign state_out = state_q;
  assign mode_chg  = mode_chg_q;
  assign req_err   = req_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_lamp_mode_sched.sv
// Directed bench for lamp_mode_sched: expected mode changes and error pulses
// are queued with their due cycle and matched as the DUT produces them.
module tb_lamp_mode_sched;
  import lamp_pkg::*;

  localparam int unsigned DEB  = 4;
  localparam int unsigned HOLD = 16;
  localparam int unsigned TURN = 64;
  // key drive -> state_out: 2 sync + DEB debounce + pulse-to-pending + pending-to-state
  localparam int LAT = int'(DEB) + 4;

  logic                sys_clk = 1'b0;
  logic                sys_rst_n;
  logic [NUM_KEYS-1:0] key_n;
  logic [MODE_W-1:0]   state_out;
  logic                mode_chg, busy, req_err;

  always #5 sys_clk = ~sys_clk;

  lamp_mode_sched #(
    .DEB_CYCLES  (DEB),
    .HOLD_CYCLES (HOLD),
    .TURN_CYCLES (TURN)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key_n     (key_n),
    .state_out (state_out),
    .mode_chg  (mode_chg),
    .busy      (busy),
    .req_err   (req_err)
  );

  typedef struct {
    logic [MODE_W-1:0] mode;
    int                cyc;
  } chg_t;

  chg_t              chg_q[$];
  int                err_q[$];
  int                cyc;
  int                n_assert;
  int                n_fail;
  logic [MODE_W-1:0] prev_state;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic exp_chg(input logic [MODE_W-1:0] m, input int c);
    chg_q.push_back('{mode: m, cyc: c});
  endtask

  task automatic exp_err(input int c);
    err_q.push_back(c);
  endtask

  // One clock; outputs sampled on the falling edge and matched to the queues.
  task automatic step();
    chg_t e;
    int   ec;
    @(posedge sys_clk);
    cyc++;
    @(negedge sys_clk);
    chk("chg_vs_state", 32'(state_out !== prev_state), 32'(mode_chg));
    if (mode_chg === 1'b1) begin
      chk("chg_expected", 32'(chg_q.size() != 0), 32'd1);
      if (chg_q.size() != 0) begin
        e = chg_q.pop_front();
        chk("chg_state", 32'(state_out), 32'(e.mode));
        chk("chg_cycle", cyc, e.cyc);
      end
    end
    if (req_err === 1'b1) begin
      chk("err_expected", 32'(err_q.size() != 0), 32'd1);
      if (err_q.size() != 0) begin
        ec = err_q.pop_front();
        chk("err_cycle", cyc, ec);
      end
    end
    prev_state = state_out;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic drain(input int bound);
    int k;
    k = 0;
    while ((chg_q.size() != 0 || err_q.size() != 0) && k < bound) begin
      step();
      k++;
    end
    chk("drain_pending", 32'(chg_q.size() + err_q.size()), 32'd0);
    chg_q.delete();
    err_q.delete();
  endtask

  initial begin
    int t, g2, l2, s1, nbusy;
    logic stop_loop;
    n_assert   = 0;
    n_fail     = 0;
    cyc        = 0;
    prev_state = MODE_STOP;
    sys_rst_n  = 1'b0;
    key_n      = '1;

    // Reset values
    repeat (3) @(negedge sys_clk);
    chk("rst_state", 32'(state_out), 32'(MODE_STOP));
    chk("rst_mode_chg", 32'(mode_chg), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_err", 32'(req_err), 32'd0);
    sys_rst_n = 1'b1;
    run(10);

    // STOP -> GO, busy for exactly HOLD cycles
    t = cyc;
    key_n[K_GO] = 1'b0;
    exp_chg(MODE_GO, t + LAT);
    drain(40);
    nbusy = 0;
    stop_loop = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (!stop_loop) begin
        if (busy !== 1'b1) begin
          stop_loop = 1'b1;
        end else begin
          nbusy++;
          if (i == 2) key_n[K_GO] = 1'b1;
          step();
        end
      end
    end
    chk("busy_cycles", nbusy, HOLD);

    // GO -> BACK is illegal
    t = cyc;
    key_n[K_BACK] = 1'b0;
    exp_err(t + LAT);
    drain(40);
    key_n[K_BACK] = 1'b1;
    chk("go_kept_after_err", 32'(state_out), 32'(MODE_GO));

    // GO -> RIGHT immediately, then auto-cancel back to GO
    run(10);
    t = cyc;
    key_n[K_RIGHT] = 1'b0;
    exp_chg(MODE_RIGHT, t + LAT);
    g2 = t + LAT + int'(TURN) + 1;
    exp_chg(MODE_GO, g2);
    run(10);
    key_n[K_RIGHT] = 1'b1;
    drain(120);

    // LEFT pressed at dwell 5 waits for the dwell to expire
    run(5);
    key_n[K_LEFT] = 1'b0;
    l2 = g2 + int'(HOLD) + 1;
    exp_chg(MODE_LEFT, l2);
    run(10);
    key_n[K_LEFT] = 1'b1;
    drain(40);
    chk("busy_in_left", 32'(busy), 32'd1);

    // STOP overrides busy
    t = cyc;
    key_n[K_STOP] = 1'b0;
    s1 = t + LAT;
    exp_chg(MODE_STOP, s1);
    run(LAT - 1);
    chk("busy_before_stop", 32'(busy), 32'd1);
    drain(20);
    key_n[K_STOP] = 1'b1;

    // BACK and GO together in STOP: BACK wins, GO is dropped
    key_n[K_BACK] = 1'b0;
    key_n[K_GO]   = 1'b0;
    exp_chg(MODE_BACK, s1 + int'(HOLD) + 1);
    run(10);
    key_n[K_BACK] = 1'b1;
    key_n[K_GO]   = 1'b1;
    drain(40);
    run(40);
    chk("back_kept", 32'(state_out), 32'(MODE_BACK));

    // BACK -> STOP, then bounced GO followed by a steady hold
    t = cyc;
    key_n[K_STOP] = 1'b0;
    exp_chg(MODE_STOP, t + LAT);
    run(10);
    key_n[K_STOP] = 1'b1;
    drain(20);
    for (int k = 0; k < 3; k++) begin
      key_n[K_GO] = 1'b0;
      run(3);
      key_n[K_GO] = 1'b1;
      run(3);
    end
    t = cyc;
    key_n[K_GO] = 1'b0;
    exp_chg(MODE_GO, t + LAT);
    run(30);
    key_n[K_GO] = 1'b1;
    drain(10);
    run(10);

    // Reset while in LEFT with RIGHT held and pending
    t = cyc;
    key_n[K_LEFT] = 1'b0;
    exp_chg(MODE_LEFT, t + LAT);
    drain(20);
    key_n[K_LEFT]  = 1'b1;
    key_n[K_RIGHT] = 1'b0;
    run(10);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("mid_rst_state", 32'(state_out), 32'(MODE_STOP));
    chk("mid_rst_mode_chg", 32'(mode_chg), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    prev_state = state_out;
    run(3);
    sys_rst_n = 1'b1;
    run(40);
    chk("held_right_ignored", 32'(state_out), 32'(MODE_STOP));
    key_n[K_RIGHT] = 1'b1;
    run(12);
    t = cyc;
    key_n[K_RIGHT] = 1'b0;
    exp_err(t + LAT);
    run(10);
    key_n[K_RIGHT] = 1'b1;
    drain(20);
    run(10);
    chk("final_state", 32'(state_out), 32'(MODE_STOP));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
